// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, MEM-stage FSM states and opcode class helpers shared by the pipeline.
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  typedef enum logic {S_RUN, S_WAIT} state_t;
  function automatic logic is_mem(input logic [5:0] op);
    return op == OP_LW || op == OP_SW;
  endfunction
  function automatic logic is_ctl(input logic [5:0] op);
    return op == OP_BEQ || op == OP_BNE || op == OP_J;
  endfunction
endpackage

// File: rtl/mem_stage.sv
// mem_stage: latches EX results, redirects branches, runs load/store handshake with timeout,
// and presents registered write-back results.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [5:0]  ex_op,
  input  logic        ex_cond,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_b,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_err
);
  localparam int CW = $clog2(MEM_TIMEOUT);
  state_t r_state, w_next;
  logic r_m_valid, r_cond, r_wb_valid, r_wb_we, r_mem_err;
  logic [5:0] r_op;
  logic [31:0] r_alu, r_addr, r_b, r_wb_data;
  logic [4:0] r_rd, r_wb_rd;
  logic [CW-1:0] r_cnt;
  logic w_wait, w_cap, w_start, w_tout, w_done, w_direct, w_misal, w_pulse;
  assign w_wait   = r_state == S_WAIT;
  assign w_cap    = ex_valid && !w_wait;
  assign w_start  = w_cap && is_mem(ex_op) && ex_alu[1:0] == 2'b00;
  assign w_tout   = w_wait && !dmem_ack && r_cnt == CW'(MEM_TIMEOUT - 1);
  assign w_done   = w_wait && (dmem_ack || w_tout);
  assign w_misal  = r_m_valid && is_mem(r_op) && r_alu[1:0] != 2'b00;
  // Aligned memory ops complete through the FSM, everything else one edge after capture.
  assign w_direct = r_m_valid && !(is_mem(r_op) && r_alu[1:0] == 2'b00);
  assign w_pulse  = w_direct || w_done;
  always_comb begin
    w_next = r_state;
    w_next = w_start ? S_WAIT : (w_done ? S_RUN : r_state);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid  <= 1'b0;
      r_op       <= '0;
      r_cond     <= 1'b0;
      r_alu      <= '0;
      r_addr     <= '0;
      r_b        <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_m_valid <= w_cap;
      if (w_cap) begin
        r_op   <= ex_op;
        r_cond <= ex_cond;
        r_alu  <= ex_alu;
        r_addr <= ex_addr;
        r_b    <= ex_b;
        r_rd   <= ex_rd;
      end
      r_cnt      <= w_start ? '0 : (w_wait ? r_cnt + 1'b1 : r_cnt);
      r_wb_valid <= w_pulse;
      r_wb_we    <= w_wait ? (dmem_ack && r_op == OP_LW && |r_rd)
                           : (w_direct && !is_mem(r_op) && !is_ctl(r_op) && |r_rd);
      if (w_pulse) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= (w_wait && dmem_ack && r_op == OP_LW) ? dmem_rdata : r_alu;
      end
      r_mem_err <= r_mem_err || w_misal || w_tout;
    end
  end
  assign stall      = w_wait;
  assign pc_sel     = r_m_valid && (((r_op == OP_BEQ || r_op == OP_BNE) && r_cond) || r_op == OP_J);
  assign pc_target  = r_addr;
  assign dmem_req   = w_wait;
  assign dmem_we    = w_wait && r_op == OP_SW;
  assign dmem_addr  = w_wait ? r_alu : '0;
  assign dmem_wdata = w_wait ? r_b : '0;
  assign wb_valid   = r_wb_valid;
  assign wb_we      = r_wb_we;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;
  assign mem_err    = r_mem_err;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random ops checked against a transaction-level model of the MEM stage.
module tb_mem_stage;
  import cpu_pkg::*;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic ex_valid = 1'b0, ex_cond = 1'b0, dmem_ack = 1'b0;
  logic [5:0] ex_op = '0;
  logic [31:0] ex_alu = '0, ex_addr = '0, ex_b = '0, dmem_rdata = '0;
  logic [4:0] ex_rd = '0;
  logic stall, pc_sel, dmem_req, dmem_we, wb_valid, wb_we, mem_err;
  logic [31:0] pc_target, dmem_addr, dmem_wdata, wb_data;
  logic [4:0] wb_rd;
  int checks = 0, errors = 0;
  logic exp_err = 1'b0;
  logic [5:0] ops [7] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, 6'b001000};

  mem_stage #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_cond(ex_cond),
    .ex_alu(ex_alu), .ex_addr(ex_addr), .ex_b(ex_b), .ex_rd(ex_rd), .stall(stall),
    .pc_sel(pc_sel), .pc_target(pc_target), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // k: cycle of S_WAIT in which ack arrives (0 = never).
  task automatic run_op(input logic [5:0] op, input logic cond, input logic [31:0] alu,
                        input logic [31:0] addr, input logic [31:0] b, input logic [4:0] rd,
                        input int k, input logic [31:0] rdata);
    logic mem, aligned, taken, we, acked;
    logic [31:0] data;
    mem = op == OP_LW || op == OP_SW;
    aligned = alu[1:0] == 2'b00;
    taken = ((op == OP_BEQ || op == OP_BNE) && cond) || op == OP_J;
    chk("stall_before", stall, 0);
    ex_valid = 1'b1; ex_op = op; ex_cond = cond; ex_alu = alu; ex_addr = addr; ex_b = b; ex_rd = rd;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0; ex_op = 6'($urandom); ex_cond = 1'($urandom); ex_alu = $urandom;
    ex_addr = $urandom; ex_b = $urandom; ex_rd = 5'($urandom);
    chk("pc_sel", pc_sel, taken);
    if (taken) chk("pc_target", pc_target, addr);
    chk("stall_c1", stall, mem && aligned);
    chk("wb_valid_c1", wb_valid, 0);
    if (mem && aligned) begin
      for (int c = 1; c <= TO; c++) begin
        chk("wait_stall", stall, 1);
        chk("dmem_req", dmem_req, 1);
        chk("dmem_addr", dmem_addr, alu);
        chk("dmem_we", dmem_we, op == OP_SW);
        chk("dmem_wdata", dmem_wdata, b);
        dmem_ack = (c == k);
        dmem_rdata = rdata;
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        if (c == k) break;
      end
      acked = k >= 1 && k <= TO;
      if (!acked) exp_err = 1'b1;
      we = acked && op == OP_LW && rd != 0;
      data = rdata;
    end else begin
      chk("no_req", dmem_req, 0);
      dmem_ack = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      dmem_ack = 1'b0;
      if (mem) exp_err = 1'b1;
      we = !mem && !(op == OP_BEQ || op == OP_BNE || op == OP_J) && rd != 0;
      data = alu;
    end
    chk("wb_valid", wb_valid, 1);
    chk("wb_we", wb_we, we);
    if (we) begin
      chk("wb_rd", wb_rd, rd);
      chk("wb_data", wb_data, data);
    end
    chk("mem_err", mem_err, exp_err);
    chk("stall_after", stall, 0);
    chk("pc_sel_after", pc_sel, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_pc_sel", pc_sel, 0);
    chk("rst_pc_target", pc_target, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mem_err", mem_err, 0);
    rst = 1'b0;
    @(negedge clk);
    run_op(OP_RTYPE, 0, 32'h3, 32'h0, 32'h0, 5, 0, 0);
    run_op(OP_BEQ, 1, 32'h1, 32'h40, 32'h0, 3, 0, 0);
    run_op(OP_BEQ, 0, 32'h1, 32'h40, 32'h0, 3, 0, 0);
    run_op(OP_BNE, 1, 32'h0, 32'h80, 32'h0, 4, 0, 0);
    run_op(OP_J, 0, 32'h9, 32'h100, 32'h0, 6, 0, 0);
    run_op(OP_RTYPE, 0, 32'h77, 32'h0, 32'h0, 0, 0, 0);
    run_op(OP_LW, 0, 32'h10, 32'h0, 32'h0, 7, 3, 32'hDEADBEEF);
    run_op(OP_SW, 0, 32'h8, 32'h0, 32'h55, 2, 1, 32'h0);
    run_op(OP_RTYPE, 0, 32'h1234, 32'h0, 32'h0, 9, 0, 0);
    run_op(OP_LW, 0, 32'h6, 32'h0, 32'h0, 8, 1, 32'h0);
    run_op(OP_LW, 0, 32'h20, 32'h0, 32'h0, 8, 0, 32'h0);
    run_op(OP_LW, 0, 32'h24, 32'h0, 32'h0, 10, TO, 32'hCAFEF00D);
    ex_valid = 1'b1; ex_op = OP_LW; ex_alu = 32'h30; ex_rd = 5'd11;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("mid_req", dmem_req, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_err", mem_err, 0);
    chk("mid_rst_wb", wb_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_wb2", wb_valid, 0);
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int k;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      k = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      run_op(ops[$urandom_range(0, 6)], 1'($urandom), a, $urandom, $urandom, 5'($urandom), k, $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
